// File: rtl/cache_refill_writer.sv
// cache_refill_writer: collects a cache-line refill as WORD_W-bit memory
// beats, merges an optional pending store into the line, then writes the
// assembled line into one data way for exactly one cycle.
//
// Handshake: the memory return bus has no ready. A beat is accepted on
// every rising edge in RECV where ret_valid=1. ret_valid is ignored in any
// other state. refill_req is only sampled in IDLE.
module cache_refill_writer #(
    parameter int LINE_W = 128,
    parameter int WORD_W = 32,
    parameter int OFF_W  = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                refill_req,
    input  logic [1:0]          refill_way,
    input  logic                st_valid,
    input  logic [OFF_W-1:0]    st_off,
    input  logic [WORD_W/8-1:0] st_wstrb,
    input  logic [WORD_W-1:0]   st_wdata,
    input  logic                ret_valid,
    input  logic                ret_last,
    input  logic [WORD_W-1:0]   ret_data,
    output logic                busy,
    output logic [1:0]          way_we,
    output logic [LINE_W-1:0]   line_wdata,
    output logic                done,
    output logic                err
);

    localparam int BEATS = LINE_W / WORD_W;
    localparam int NBYTE = WORD_W / 8;
    localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e              state_q;
    logic [OFF_W-1:0]    cnt_q;
    logic [1:0]          way_q;
    logic                st_valid_q;
    logic [OFF_W-1:0]    st_off_q;
    logic [NBYTE-1:0]    st_wstrb_q;
    logic [WORD_W-1:0]   st_wdata_q;
    logic [LINE_W-1:0]   line_q;
    logic [1:0]          way_we_q;
    logic                done_q;
    logic                err_q;
    logic [WORD_W-1:0]   beat_word_d;

    // Merge the latched store over the incoming beat; store bytes win.
    always_comb begin
        beat_word_d = ret_data;
        if (st_valid_q && (cnt_q == st_off_q)) begin
            for (int b = 0; b < NBYTE; b++) begin
                if (st_wstrb_q[b]) begin
                    beat_word_d[b*8 +: 8] = st_wdata_q[b*8 +: 8];
                end
            end
        end
    end

    // Refill FSM: IDLE -> RECV -> WRITE -> IDLE, with registered pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            way_q      <= 2'b00;
            st_valid_q <= 1'b0;
            st_off_q   <= '0;
            st_wstrb_q <= '0;
            st_wdata_q <= '0;
            line_q     <= '0;
            way_we_q   <= 2'b00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // way_we, done and err are single-cycle pulses by default.
            way_we_q <= 2'b00;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (refill_req && (refill_way != 2'b00)) begin
                        // Way encoding 11 folds onto way2.
                        way_q      <= (refill_way == 2'b01) ? 2'b01 : 2'b10;
                        st_valid_q <= st_valid;
                        st_off_q   <= st_off;
                        st_wstrb_q <= st_wstrb;
                        st_wdata_q <= st_wdata;
                        cnt_q      <= '0;
                        line_q     <= '0;
                        state_q    <= RECV;
                    end
                end
                RECV: begin
                    if (ret_valid) begin
                        for (int w = 0; w < BEATS; w++) begin
                            if (cnt_q == OFF_W'(w)) begin
                                line_q[w*WORD_W +: WORD_W] <= beat_word_d;
                            end
                        end
                        if (cnt_q == LAST_CNT) begin
                            // Final beat: write goes out next cycle, err flags a missing last.
                            way_we_q <= way_q;
                            done_q   <= 1'b1;
                            err_q    <= ~ret_last;
                            cnt_q    <= '0;
                            state_q  <= WRITE;
                        end else if (ret_last) begin
                            // Early last: drop the partial line, no write.
                            err_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign way_we     = way_we_q;
    assign line_wdata = line_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cache_refill_writer.sv
// Directed bench for cache_refill_writer. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_cache_refill_writer;

    localparam int LINE_W = 128;
    localparam int WORD_W = 32;
    localparam int OFF_W  = 2;

    logic                clk;
    logic                rstn;
    logic                refill_req;
    logic [1:0]          refill_way;
    logic                st_valid;
    logic [OFF_W-1:0]    st_off;
    logic [WORD_W/8-1:0] st_wstrb;
    logic [WORD_W-1:0]   st_wdata;
    logic                ret_valid;
    logic                ret_last;
    logic [WORD_W-1:0]   ret_data;
    logic                busy;
    logic [1:0]          way_we;
    logic [LINE_W-1:0]   line_wdata;
    logic                done;
    logic                err;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [LINE_W-1:0] LINE_PLAIN  = 128'h44444444_33333333_22222222_11111111;
    localparam logic [LINE_W-1:0] LINE_MERGE  = 128'h44444444_3333ABCD_22222222_11111111;
    localparam logic [LINE_W-1:0] LINE_CLEAN  = 128'h88888888_77777777_66666666_55555555;

    cache_refill_writer #(
        .LINE_W(LINE_W),
        .WORD_W(WORD_W),
        .OFF_W (OFF_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .refill_req(refill_req),
        .refill_way(refill_way),
        .st_valid  (st_valid),
        .st_off    (st_off),
        .st_wstrb  (st_wstrb),
        .st_wdata  (st_wdata),
        .ret_valid (ret_valid),
        .ret_last  (ret_last),
        .ret_data  (ret_data),
        .busy      (busy),
        .way_we    (way_we),
        .line_wdata(line_wdata),
        .done      (done),
        .err       (err)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Checks the four control outputs at once.
    task automatic check_ctl(input string tag, input logic b, input logic [1:0] we,
                             input logic d, input logic e);
        check({tag, ".busy"},   LINE_W'(busy),   LINE_W'(b));
        check({tag, ".way_we"}, LINE_W'(way_we), LINE_W'(we));
        check({tag, ".done"},   LINE_W'(done),   LINE_W'(d));
        check({tag, ".err"},    LINE_W'(err),    LINE_W'(e));
    endtask

    // Present a refill request for one cycle, then clear the store fields.
    task automatic start(input logic [1:0] way, input logic sv, input logic [1:0] off,
                         input logic [3:0] strb, input logic [31:0] d);
        refill_req = 1'b1;
        refill_way = way;
        st_valid   = sv;
        st_off     = off;
        st_wstrb   = strb;
        st_wdata   = d;
        @(negedge clk);
        refill_req = 1'b0;
        refill_way = 2'b00;
        st_valid   = 1'b0;
        st_off     = '0;
        st_wstrb   = '0;
        st_wdata   = '0;
    endtask

    // Drive one return beat for one cycle.
    task automatic beat(input logic [31:0] d, input logic last);
        ret_valid = 1'b1;
        ret_data  = d;
        ret_last  = last;
        @(negedge clk);
        ret_valid = 1'b0;
        ret_last  = 1'b0;
        ret_data  = '0;
    endtask

    task automatic four_beats(input logic last_on_4th);
        beat(32'h11111111, 1'b0);
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b0);
        beat(32'h44444444, last_on_4th);
    endtask

    initial begin
        rstn       = 1'b0;
        refill_req = 1'b0;
        refill_way = 2'b00;
        st_valid   = 1'b0;
        st_off     = '0;
        st_wstrb   = '0;
        st_wdata   = '0;
        ret_valid  = 1'b0;
        ret_last   = 1'b0;
        ret_data   = '0;
        repeat (2) @(negedge clk);
        check_ctl("reset", 1'b0, 2'b00, 1'b0, 1'b0);
        check("reset.line", line_wdata, '0);
        rstn = 1'b1;
        @(negedge clk);

        // 1: plain refill into way1.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        check("t1.busy_recv", LINE_W'(busy), LINE_W'(1'b1));
        four_beats(1'b1);
        check_ctl("t1.write", 1'b1, 2'b01, 1'b1, 1'b0);
        check("t1.line", line_wdata, LINE_PLAIN);
        @(negedge clk);
        check_ctl("t1.after", 1'b0, 2'b00, 1'b0, 1'b0);

        // 2: store merge into word2, way2.
        start(2'b10, 1'b1, 2'd2, 4'b0011, 32'h0000ABCD);
        four_beats(1'b1);
        check_ctl("t2.write", 1'b1, 2'b10, 1'b1, 1'b0);
        check("t2.line", line_wdata, LINE_MERGE);
        @(negedge clk);

        // 3: gap of three idle cycles between beats 1 and 2.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        beat(32'h11111111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_ctl("t3.gap", 1'b1, 2'b00, 1'b0, 1'b0);
            @(negedge clk);
        end
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b0);
        check_ctl("t3.pre", 1'b1, 2'b00, 1'b0, 1'b0);
        beat(32'h44444444, 1'b1);
        check_ctl("t3.write", 1'b1, 2'b01, 1'b1, 1'b0);
        check("t3.line", line_wdata, LINE_PLAIN);
        @(negedge clk);
        check_ctl("t3.after", 1'b0, 2'b00, 1'b0, 1'b0);

        // 4a: last on the first beat -> err, no write, back to IDLE.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        beat(32'h11111111, 1'b1);
        check_ctl("t4a.err", 1'b0, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        check_ctl("t4a.after", 1'b0, 2'b00, 1'b0, 1'b0);

        // 4b: last missing on the final beat -> write plus err together.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        four_beats(1'b0);
        check_ctl("t4b.write", 1'b1, 2'b01, 1'b1, 1'b1);
        check("t4b.line", line_wdata, LINE_PLAIN);
        @(negedge clk);
        check_ctl("t4b.after", 1'b0, 2'b00, 1'b0, 1'b0);

        // 5a: way 00 request is ignored.
        refill_req = 1'b1;
        refill_way = 2'b00;
        @(negedge clk);
        refill_req = 1'b0;
        check("t5a.busy", LINE_W'(busy), LINE_W'(1'b0));
        @(negedge clk);
        check("t5a.busy2", LINE_W'(busy), LINE_W'(1'b0));

        // 5b: way 11 folds onto way2.
        start(2'b11, 1'b0, 2'd0, 4'b0000, 32'h0);
        four_beats(1'b1);
        check_ctl("t5b.write", 1'b1, 2'b10, 1'b1, 1'b0);
        @(negedge clk);

        // 5c: requests during RECV are ignored; one done pulse only.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        beat(32'h11111111, 1'b0);
        refill_req = 1'b1;
        refill_way = 2'b10;
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b0);
        refill_req = 1'b0;
        refill_way = 2'b00;
        check_ctl("t5c.pre", 1'b1, 2'b00, 1'b0, 1'b0);
        beat(32'h44444444, 1'b1);
        check_ctl("t5c.write", 1'b1, 2'b01, 1'b1, 1'b0);
        check("t5c.line", line_wdata, LINE_PLAIN);
        @(negedge clk);
        check_ctl("t5c.after", 1'b0, 2'b00, 1'b0, 1'b0);

        // 6: async reset after two beats, then a clean refill.
        start(2'b01, 1'b1, 2'd0, 4'b1111, 32'hDEADBEEF);
        beat(32'hAAAAAAAA, 1'b0);
        beat(32'hBBBBBBBB, 1'b0);
        rstn = 1'b0;
        #1;
        check_ctl("t6.reset", 1'b0, 2'b00, 1'b0, 1'b0);
        check("t6.reset_line", line_wdata, '0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("t6.idle", LINE_W'(busy), LINE_W'(1'b0));
        start(2'b10, 1'b0, 2'd0, 4'b0000, 32'h0);
        beat(32'h55555555, 1'b0);
        beat(32'h66666666, 1'b0);
        beat(32'h77777777, 1'b0);
        beat(32'h88888888, 1'b1);
        check_ctl("t6.write", 1'b1, 2'b10, 1'b1, 1'b0);
        check("t6.line", line_wdata, LINE_CLEAN);
        @(negedge clk);

        // Back-to-back: request in the first IDLE cycle after WRITE.
        start(2'b01, 1'b0, 2'd0, 4'b0000, 32'h0);
        four_beats(1'b1);
        check_ctl("b2b.write1", 1'b1, 2'b01, 1'b1, 1'b0);
        @(negedge clk);
        start(2'b10, 1'b1, 2'd2, 4'b0011, 32'h0000ABCD);
        check("b2b.busy", LINE_W'(busy), LINE_W'(1'b1));
        four_beats(1'b1);
        check_ctl("b2b.write2", 1'b1, 2'b10, 1'b1, 1'b0);
        check("b2b.line", line_wdata, LINE_MERGE);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
